conv_mac_scheduler: RTL and testbench

//  Sequences one KERNEL_SIZE x KERNEL_SIZE convolution window through the shared pipelined multiplier.
//  Per window it generates weight/feature buffer read addresses, issues operand pairs to the multiplier,
//  and accumulates the returned products. The window sum is then presented on a valid/ready output.

---
 rtl/conv_mac_scheduler_pkg.sv | 31 +++
 rtl/conv_mac_scheduler_if.sv | 38 +++
 rtl/conv_mac_scheduler_window_addr_gen.sv | 64 ++++++
 rtl/conv_mac_scheduler.sv | 105 ++++++++++
 tb/tb_conv_mac_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_mac_scheduler_pkg.sv
// Shared types and sizing helpers for the convolution MAC scheduler.
// No logic; the state enum and width math are common to the top, its interface and its sub-module.
package conv_mac_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Worst-case window sum KK*(2^BW-1)^2 always fits in this width.
  function automatic int acc_width(input int bw, input int k);
    return 2 * bw + clog2_f(k * k);
  endfunction

  localparam int BIT_WIDTH_DEF   = 8;
  localparam int KERNEL_SIZE_DEF = 3;
  localparam int KK_DEF          = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int ACC_WIDTH_DEF   = 2 * BIT_WIDTH_DEF + clog2_f(KK_DEF);

endpackage

// File: rtl/conv_mac_scheduler_if.sv
// Scheduler-facing bundle: start/base, buffer reads, multiplier operands/product, and the sum handshake.
// master = scheduler side, slave = the surrounding buffers, multiplier and consumer.
interface conv_mac_scheduler_if import conv_mac_scheduler_pkg::*; #(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) ();

  logic                   i_start;
  logic [ADDR_WIDTH-1:0]  i_f_base;
  logic                   o_busy;
  logic                   o_rd_en;
  logic [ADDR_WIDTH-1:0]  o_w_addr;
  logic [ADDR_WIDTH-1:0]  o_f_addr;
  logic [BIT_WIDTH-1:0]   i_pix_weight;
  logic [BIT_WIDTH-1:0]   i_pix_feature;
  logic                   o_mul_en;
  logic [BIT_WIDTH-1:0]   o_mul_a;
  logic [BIT_WIDTH-1:0]   o_mul_b;
  logic [2*BIT_WIDTH-1:0] i_mul_p;
  logic [ACC_WIDTH-1:0]   o_sum;
  logic                   o_sum_valid;
  logic                   i_sum_ready;
  logic                   o_done;

  modport master (
    input  i_start, i_f_base, i_pix_weight, i_pix_feature, i_mul_p, i_sum_ready,
    output o_busy, o_rd_en, o_w_addr, o_f_addr, o_mul_en, o_mul_a, o_mul_b,
           o_sum, o_sum_valid, o_done
  );

  modport slave (
    output i_start, i_f_base, i_pix_weight, i_pix_feature, i_mul_p, i_sum_ready,
    input  o_busy, o_rd_en, o_w_addr, o_f_addr, o_mul_en, o_mul_a, o_mul_b,
           o_sum, o_sum_valid, o_done
  );

endinterface

// File: rtl/conv_mac_scheduler_window_addr_gen.sv
// Raster-order tap walker: weight address = tap, feature address = base + row offset + column.
// Addresses are registered and valid the cycle after load/step; the row offset is a running sum, not a multiply.
module window_addr_gen import conv_mac_scheduler_pkg::*; #(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMG_WIDTH   = 28,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [ADDR_WIDTH-1:0] o_f_addr,
  output logic                  o_last
);

  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;

  logic [ADDR_WIDTH-1:0] tap_q, tap_d;
  logic [ADDR_WIDTH-1:0] c_q, c_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  assign o_last   = (tap_q == ADDR_WIDTH'(KK - 1));
  assign o_w_addr = tap_q;
  assign o_f_addr = base_q + row_q + c_q;

  always_comb begin
    tap_d  = tap_q;
    c_d    = c_q;
    row_d  = row_q;
    base_d = base_q;
    if (i_load) begin
      tap_d  = '0;
      c_d    = '0;
      row_d  = '0;
      base_d = i_base;
    end else if (i_step && !o_last) begin
      tap_d = tap_q + 1'b1;
      if (c_q == ADDR_WIDTH'(KERNEL_SIZE - 1)) begin
        c_d   = '0;
        row_d = row_q + ADDR_WIDTH'(IMG_WIDTH);
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tap_q  <= '0;
      c_q    <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      tap_q  <= tap_d;
      c_q    <= c_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/conv_mac_scheduler.sv
// Runs one KxK window through the shared multiplier and accumulates the products into a window sum.
// Sum valid KK+2+MUL_LATENCY cycles after start; held stable under i_sum_ready=0, o_done pulses after the handshake.
module conv_mac_scheduler import conv_mac_scheduler_pkg::*; #(
  parameter int BIT_WIDTH   = BIT_WIDTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMG_WIDTH   = 28,
  parameter int ADDR_WIDTH  = 10,
  parameter int MUL_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  conv_mac_scheduler_if.master bus
);

  localparam int ACC_W = acc_width(BIT_WIDTH, KERNEL_SIZE);
  // Every product stage except the one being accumulated this edge.
  localparam logic [MUL_LATENCY-1:0] PEND_MASK = {MUL_LATENCY{1'b1}} >> 1;

  state_e                 state_q, state_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [MUL_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   done_q, done_d;

  logic issue, load, last_tap, pending, handshake;

  window_addr_gen #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_WIDTH   (IMG_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load),
    .i_base   (bus.i_f_base),
    .i_step   (issue),
    .o_w_addr (bus.o_w_addr),
    .o_f_addr (bus.o_f_addr),
    .o_last   (last_tap)
  );

  assign issue   = (state_q == ISSUE);
  assign pending = rd_vld_q | (|(vld_sr_q & PEND_MASK));

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: if (last_tap) state_d = DRAIN;
      DRAIN: if (!pending) state_d = OUT;
      OUT: begin
        if (bus.i_sum_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_vld_d = issue;
    vld_sr_d = (vld_sr_q << 1) | MUL_LATENCY'(rd_vld_q);
    done_d   = handshake;
    acc_d    = acc_q;
    if (load) begin
      acc_d = '0;
    end else if (vld_sr_q[MUL_LATENCY-1]) begin
      acc_d = acc_q + ACC_W'(bus.i_mul_p);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      rd_vld_q <= 1'b0;
      vld_sr_q <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_vld_d;
      vld_sr_q <= vld_sr_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_busy      = (state_q != IDLE) | done_q;
  assign bus.o_rd_en     = issue;
  assign bus.o_mul_en    = rd_vld_q;
  assign bus.o_mul_a     = bus.i_pix_weight;
  assign bus.o_mul_b     = bus.i_pix_feature;
  assign bus.o_sum       = acc_q;
  assign bus.o_sum_valid = (state_q == OUT);
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Bench for conv_mac_scheduler: behavioural buffers and multiplier around the DUT, window sums from a direct model.
module tb_conv_mac_scheduler;

  localparam int BW   = 8;
  localparam int K    = 3;
  localparam int KK   = K * K;
  localparam int IMG  = 28;
  localparam int AW   = 10;
  localparam int L    = 2;
  localparam int ACCW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_mac_scheduler_if #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) bus ();

  conv_mac_scheduler #(
    .BIT_WIDTH(BW), .KERNEL_SIZE(K), .IMG_WIDTH(IMG), .ADDR_WIDTH(AW), .MUL_LATENCY(L)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BW-1:0]   wmem [0:1023];
  logic [BW-1:0]   fmem [0:1023];
  logic [2*BW-1:0] prod_at [0:63];
  bit              pv [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Buffers answer one cycle after a read; the multiplier returns a*b L cycles after its strobe, garbage otherwise.
  initial begin
    int n;
    logic rd;
    logic [AW-1:0] wa, fa;
    int s;
    n = 0;
    for (int i = 0; i < 64; i++) pv[i] = 1'b0;
    bus.i_pix_weight  = '0;
    bus.i_pix_feature = '0;
    bus.i_mul_p       = '0;
    forever begin
      @(negedge clk);
      rd = bus.o_rd_en;
      wa = bus.o_w_addr;
      fa = bus.o_f_addr;
      if (bus.o_mul_en === 1'b1) begin
        prod_at[(n + L) % 64] = bus.o_mul_a * bus.o_mul_b;
        pv[(n + L) % 64]      = 1'b1;
      end
      @(posedge clk);
      #1;
      s = (n + 1) % 64;
      n++;
      bus.i_pix_weight  = rd ? wmem[wa] : BW'($urandom);
      bus.i_pix_feature = rd ? fmem[fa] : BW'($urandom);
      if (pv[s]) begin
        bus.i_mul_p = prod_at[s];
        pv[s]       = 1'b0;
      end else begin
        bus.i_mul_p = (2*BW)'($urandom);
      end
    end
  end

  task automatic load_count(input logic [AW-1:0] base, input logic [BW-1:0] wval);
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = wval;
      fmem[i] = '0;
    end
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        fmem[AW'(base + r * IMG + c)] = BW'(r * K + c + 1);
  endtask

  // Enter at a negedge; starts a window there. Returns at the o_done negedge (or after a mid-window reset).
  task automatic run_window(input logic [AW-1:0] base, input int hold, input int start_k,
                            input bit start_hs, input int rst_k, output logic [31:0] got_sum);
    logic [AW-1:0] exp_w[$], exp_f[$], got_w[$], got_f[$];
    logic [31:0] exp_sum, sum0;
    int first_rd, last_rd, first_mul, last_mul, n_mul, valid_k, hs_k, done_k;
    exp_sum = 0; sum0 = 0; got_sum = 0;
    first_rd = -1; last_rd = -1; first_mul = -1; last_mul = -1; n_mul = 0;
    valid_k = -1; hs_k = -1; done_k = -1;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        exp_w.push_back(AW'(r * K + c));
        exp_f.push_back(AW'(base + r * IMG + c));
        exp_sum += wmem[r * K + c] * fmem[AW'(base + r * IMG + c)];
      end
    bus.i_f_base    = base;
    bus.i_start     = 1'b1;
    bus.i_sum_ready = (hold == 0);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      bus.i_start = (k == start_k);
      if (k == rst_k) begin
        chk("tap_before_rst", bus.o_w_addr, rst_k - 1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_mul_en", bus.o_mul_en, 0);
        chk("rst_w_addr", bus.o_w_addr, 0);
        chk("rst_f_addr", bus.o_f_addr, 0);
        chk("rst_sum", bus.o_sum, 0);
        chk("rst_sum_valid", bus.o_sum_valid, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_busy", bus.o_busy, 0);
        bus.i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      chk("busy", bus.o_busy, 1);
      if (bus.o_rd_en) begin
        got_w.push_back(bus.o_w_addr);
        got_f.push_back(bus.o_f_addr);
        if (first_rd < 0) first_rd = k;
        last_rd = k;
      end
      if (bus.o_mul_en) begin
        if (first_mul < 0) first_mul = k;
        last_mul = k;
        n_mul++;
      end
      if (bus.o_done) begin
        done_k = k;
        chk("done_cycle", k, hs_k + 1);
        break;
      end
      if (bus.o_sum_valid) begin
        if (valid_k < 0) begin
          valid_k = k;
          sum0    = bus.o_sum;
        end else begin
          chk("sum_held", bus.o_sum, sum0);
        end
      end else if (valid_k >= 0) begin
        chk("valid_held", bus.o_sum_valid, 1);
      end
      if (valid_k >= 0 && k >= valid_k + hold) bus.i_sum_ready = 1'b1;
      if (bus.o_sum_valid && bus.i_sum_ready && hs_k < 0) begin
        hs_k = k;
        if (start_hs) bus.i_start = 1'b1;
      end
    end
    bus.i_start = 1'b0;
    chk("timeout", done_k > 0, 1);
    chk("valid_cycle", valid_k, KK + 2 + L);
    chk("hs_cycle", hs_k, valid_k + hold);
    chk("first_rd", first_rd, 1);
    chk("last_rd", last_rd, KK);
    chk("n_rd", got_w.size(), KK);
    chk("first_mul", first_mul, 2);
    chk("last_mul", last_mul, KK + 1);
    chk("n_mul", n_mul, KK);
    if (got_w.size() == KK) begin
      for (int i = 0; i < KK; i++) begin
        chk("w_addr", got_w[i], exp_w[i]);
        chk("f_addr", got_f[i], exp_f[i]);
      end
    end
    chk("sum", sum0, exp_sum);
    got_sum = sum0;
  endtask

  initial begin
    logic [31:0] s;
    bus.i_start     = 1'b0;
    bus.i_f_base    = '0;
    bus.i_sum_ready = 1'b0;
    load_count(10'd30, 8'd1);
    repeat (2) @(negedge clk);
    chk("reset_rd_en", bus.o_rd_en, 0);
    chk("reset_mul_en", bus.o_mul_en, 0);
    chk("reset_w_addr", bus.o_w_addr, 0);
    chk("reset_f_addr", bus.o_f_addr, 0);
    chk("reset_sum", bus.o_sum, 0);
    chk("reset_sum_valid", bus.o_sum_valid, 0);
    chk("reset_done", bus.o_done, 0);
    chk("reset_busy", bus.o_busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Counting sum and address sequence from base 30.
    run_window(10'd30, 0, 0, 1'b0, 0, s);
    chk("count_sum", s, 45);
    @(negedge clk);

    // Maximum operands.
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 8'd255;
      fmem[i] = 8'd255;
    end
    run_window(10'd30, 0, 0, 1'b0, 0, s);
    chk("max_sum", s, 585225);
    @(negedge clk);

    // Backpressure for 5 cycles in OUT.
    load_count(10'd30, 8'd1);
    run_window(10'd30, 5, 0, 1'b0, 0, s);
    chk("bp_sum", s, 45);
    @(negedge clk);
    chk("bp_done_single", bus.o_done, 0);
    chk("bp_idle", bus.o_busy, 0);

    // Starts during ISSUE and during the handshake are ignored.
    run_window(10'd30, 0, 4, 1'b1, 0, s);
    chk("busy_start_sum", s, 45);
    repeat (2) begin
      @(negedge clk);
      chk("no_restart_busy", bus.o_busy, 0);
      chk("no_restart_rd", bus.o_rd_en, 0);
    end

    // Back-to-back: second start lands in the o_done cycle.
    run_window(10'd30, 0, 0, 1'b0, 0, s);
    chk("b2b_first", s, 45);
    for (int i = 0; i < KK; i++) wmem[i] = 8'd2;
    run_window(10'd30, 0, 0, 1'b0, 0, s);
    chk("b2b_second", s, 90);
    @(negedge clk);

    // Reset at tap 4, then a clean window.
    load_count(10'd30, 8'd1);
    run_window(10'd30, 0, 0, 1'b0, 5, s);
    @(negedge clk);
    run_window(10'd30, 0, 0, 1'b0, 0, s);
    chk("post_rst_sum", s, 45);
    @(negedge clk);

    // Random windows, including a base that wraps the feature address space.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 1024; i++) begin
        wmem[i] = BW'($urandom);
        fmem[i] = BW'($urandom);
      end
      run_window((t == 0) ? 10'd1015 : AW'($urandom), $urandom_range(0, 3), 0, 1'b0, 0, s);
      if (t[0]) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
